kovacs_sequencer: RTL

KOVACS_SEQUENCER -- requirements
Module: kovacs_sequencer

---
 rtl/kovacs_pkg.sv | 16 +
 rtl/kovacs_phase_timer.sv | 28 ++
 rtl/kovacs_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/kovacs_pkg.sv
// Shared types and constants for the kovacs protocol sequencer.
package kovacs_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPhA,
    StPhB,
    StDone
  } seq_state_e;

  // Datapath select codes driven on sel_o.
  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_A    = 2'd1;
  localparam logic [1:0] SEL_B    = 2'd2;

endpackage

// File: rtl/kovacs_phase_timer.sv
// Load-and-count-down phase timer. A zero load value is treated as one so every
// phase lasts at least one cycle; expire_o flags the final cycle of the phase.
module kovacs_phase_timer #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            expire_o
);

  logic [CntW-1:0] cnt_q;

  // Counter holds the cycles remaining in the current phase, including this one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (load_val_i == '0) ? CntW'(1) : load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign expire_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/kovacs_sequencer.sv
// Protocol sequencer: alternates phase A / phase B for a programmed number of
// repetitions (0 = until stopped), with registered select/indicator/status outputs.
// Optional build macro KOVACS_SEQ_EXT_TRIG_EN adds an asynchronous trig_i whose
// synchronised rising edge acts as start_i.
module kovacs_sequencer
  import kovacs_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter logic [13:0] IND_HIGH = 14'h1FFF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
`ifdef KOVACS_SEQ_EXT_TRIG_EN
  input  logic             trig_i,
`endif
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] T1_i,
  input  logic [CNT_W-1:0] T2_i,
  input  logic [15:0]      reps_i,
  output logic [1:0]       sel_o,
  output logic [13:0]      indicator_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      rep_cnt_o
);

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  seq_state_e       state_q;
  logic [CNT_W-1:0] t1_q, t2_q;
  logic [15:0]      reps_q, rep_cnt_q, rep_next;
  logic [1:0]       sel_q;
  logic [13:0]      ind_q;
  logic             busy_q, done_q;
  logic             start_go, last_rep;
  logic             tmr_load, tmr_expire;
  logic [CNT_W-1:0] tmr_val;

  // Reset asserts asynchronously, releases two edges after rstn_i rises.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

`ifdef KOVACS_SEQ_EXT_TRIG_EN
  logic trig_meta_q, trig_sync_q, trig_prev_q;

  // Two-flop synchroniser plus edge detector on the external trigger.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_meta_q <= trig_i;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
    end
  end
  assign start_go = (start_i | (trig_sync_q & ~trig_prev_q)) & ~stop_i;
`else
  assign start_go = start_i & ~stop_i;
`endif

  assign rep_next = rep_cnt_q + 16'd1;
  assign last_rep = (reps_q != 16'd0) && (rep_next == reps_q);

  // Timer reload at each phase entry; stop or the final repetition skips the reload.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = t1_q;
    case (state_q)
      StIdle: begin
        tmr_load = start_go;
        tmr_val  = T1_i;
      end
      StPhA: begin
        tmr_load = tmr_expire & ~stop_i;
        tmr_val  = t2_q;
      end
      StPhB: begin
        tmr_load = tmr_expire & ~stop_i & ~last_rep;
        tmr_val  = t1_q;
      end
      default: ;
    endcase
  end

  kovacs_phase_timer #(
    .CntW(CNT_W)
  ) u_phase_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_expire)
  );

  // Sequencer FSM with registered outputs; stop has priority over phase expiry.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      t1_q      <= '0;
      t2_q      <= '0;
      reps_q    <= '0;
      rep_cnt_q <= '0;
      sel_q     <= SEL_IDLE;
      ind_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_go) begin
            t1_q      <= T1_i;
            t2_q      <= T2_i;
            reps_q    <= reps_i;
            rep_cnt_q <= '0;
            state_q   <= StPhA;
            sel_q     <= SEL_A;
            ind_q     <= IND_HIGH;
            busy_q    <= 1'b1;
          end
        end
        StPhA: begin
          if (stop_i) begin
            state_q <= StIdle;
            sel_q   <= SEL_IDLE;
            ind_q   <= '0;
            busy_q  <= 1'b0;
          end else if (tmr_expire) begin
            state_q <= StPhB;
            sel_q   <= SEL_B;
          end
        end
        StPhB: begin
          if (stop_i) begin
            state_q <= StIdle;
            sel_q   <= SEL_IDLE;
            ind_q   <= '0;
            busy_q  <= 1'b0;
          end else if (tmr_expire) begin
            rep_cnt_q <= rep_next;
            if (last_rep) begin
              state_q <= StDone;
              sel_q   <= SEL_IDLE;
              ind_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPhA;
              sel_q   <= SEL_A;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sel_o       = sel_q;
  assign indicator_o = ind_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rep_cnt_o   = rep_cnt_q;

endmodule
